// File: rtl/byte_serial_mem.sv
// rtl/byte_serial_mem.sv - byte-wide request/response memory with fixed read latency
//
// Purpose: byte-addressed storage of 2^ADDR_W bytes. A one-byte request is
// accepted when valid and ready are both high. Reads return through a
// READ_LAT-deep delay line with no backpressure. A write stalls while any
// read is still in flight.
//
// Ports:
//   clk          in   1   clock, all state changes on the rising edge
//   rst          in   1   synchronous active-high reset
//   mode         in   1   0 = read, 1 = write
//   valid        in   1   request present on mode/addr/w_data
//   ready        out  1   request accepted this cycle (combinational)
//   addr         in   64  byte address, low ADDR_W bits used
//   w_data       in   8   write byte
//   r_data_valid out  1   one-cycle strobe for a returned read byte
//   r_data       out  8   returned read byte, 8'h00 when r_data_valid=0

module byte_serial_mem #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        valid,
  output logic        ready,
  input  logic [63:0] addr,
  input  logic [7:0]  w_data,
  output logic        r_data_valid,
  output logic [7:0]  r_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic                unused_addr_hi;

  logic                rd_acc;
  logic                wr_acc;

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] vld_d;
  logic [7:0]          dat_q [READ_LAT];
  logic [7:0]          dat_d [READ_LAT];

  logic [2:0]          outstanding_q;
  logic [2:0]          outstanding_d;

  // Bits above ADDR_W-1 alias onto the same byte.
  assign idx            = addr[ADDR_W-1:0];
  assign unused_addr_hi = ^addr[63:ADDR_W];

  // A write must not overtake reads already in flight, so it waits until
  // every accepted read has returned.
  always_comb begin
    ready = 1'b1;
    if (rst) begin
      ready = 1'b0;
    end else if (valid && mode && (outstanding_q != 3'd0)) begin
      ready = 1'b0;
    end
  end

  assign rd_acc = valid & ready & ~mode;
  assign wr_acc = valid & ready & mode;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[idx] <= w_data;
    end
  end

  // Delay line: stage 0 captures the addressed byte at acceptance. Data is
  // forced to zero in empty stages so r_data is 8'h00 whenever no beat is due.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_acc;
    for (int i = 0; i < READ_LAT; i++) begin
      dat_d[i] = 8'h00;
    end
    dat_d[0] = rd_acc ? mem_q[idx] : 8'h00;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // A return beat and a new read in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_acc, r_data_valid})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      outstanding_q <= 3'd0;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= 8'h00;
      end
    end else begin
      vld_q         <= vld_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign r_data_valid = vld_q[READ_LAT-1];
  assign r_data       = dat_q[READ_LAT-1];

endmodule

// File: tb/tb_byte_serial_mem.sv
// tb/tb_byte_serial_mem.sv - directed self-checking bench for byte_serial_mem

module tb_byte_serial_mem;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        valid;
  logic [63:0] addr;
  logic [7:0]  w_data;

  logic        ready2, rdv2;
  logic [7:0]  rdat2;
  logic        ready1, rdv1;
  logic [7:0]  rdat1;
  logic        ready4, rdv4;
  logic [7:0]  rdat4;

  int checks;
  int errors;
  int peak;
  bit mon_en;

  byte_serial_mem #(.ADDR_W(12), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .mode(mode), .valid(valid), .ready(ready2),
    .addr(addr), .w_data(w_data), .r_data_valid(rdv2), .r_data(rdat2)
  );

  byte_serial_mem #(.ADDR_W(12), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .valid(valid), .ready(ready1),
    .addr(addr), .w_data(w_data), .r_data_valid(rdv1), .r_data(rdat1)
  );

  byte_serial_mem #(.ADDR_W(12), .READ_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .valid(valid), .ready(ready4),
    .addr(addr), .w_data(w_data), .r_data_valid(rdv4), .r_data(rdat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic m, input logic [63:0] a, input logic [7:0] d);
    valid  = 1'b1;
    mode   = m;
    addr   = a;
    w_data = d;
  endtask

  // Idle with live-looking write fields: nothing may be stored while valid=0.
  task automatic idle();
    valid  = 1'b0;
    mode   = 1'b1;
    addr   = 64'h10;
    w_data = 8'hEE;
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int k = 0; k < n; k++) step();
  endtask

  // r_data must be zero in every cycle without a beat, on every instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rdv2) chk("zero_rdata_lat2", {56'd0, rdat2}, 64'h0);
      if (!rdv1) chk("zero_rdata_lat1", {56'd0, rdat1}, 64'h0);
      if (!rdv4) chk("zero_rdata_lat4", {56'd0, rdat4}, 64'h0);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    valid  = 1'b0;
    mode   = 1'b0;
    addr   = 64'h0;
    w_data = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_ready", ready2, 1'b0);
    chk("rst_rdv", rdv2, 1'b0);
    chk("rst_rdata", rdat2, 8'h00);
    chk("rst_outst", u_dut2.outstanding_q, 3'd0);
    chk("rst_rdv4", rdv4, 1'b0);
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    chk("ready_first_cycle", ready2, 1'b1);

    // Write then read, latency 2, single beat
    drv(1'b1, 64'h10, 8'hA5);
    #1;
    chk("t1_wr_ready", ready2, 1'b1);
    step();
    drv(1'b0, 64'h10, 8'h00);
    #1;
    chk("t1_rd_ready", ready2, 1'b1);
    step();
    idle();
    #1;
    chk("t1_no_early_beat", rdv2, 1'b0);
    chk("t1_outst_1", u_dut2.outstanding_q, 3'd1);
    step();
    chk("t1_rdv", rdv2, 1'b1);
    chk("t1_rdata", rdat2, 8'hA5);
    step();
    chk("t1_single_beat", rdv2, 1'b0);
    chk("t1_outst_0", u_dut2.outstanding_q, 3'd0);

    // Eight writes, eight back-to-back reads
    idle_n(6);
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 64'h100 + 64'(i), 8'(8'h11 * (i + 1)));
      #1;
      step();
    end
    peak = 0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drv(1'b0, 64'h100 + 64'(j), 8'h00);
      else idle();
      #1;
      if (j < 8) chk("t2_ready", ready2, 1'b1);
      if (int'(u_dut2.outstanding_q) > peak) peak = int'(u_dut2.outstanding_q);
      step();
      if (j >= 1 && j <= 8) begin
        chk("t2_rdv", rdv2, 1'b1);
        chk("t2_rdata", rdat2, 64'(8'h11 * j));
      end else begin
        chk("t2_no_beat", rdv2, 1'b0);
      end
    end
    chk("t2_peak", 64'(peak), 64'd2);

    // Write-after-read stall
    idle_n(6);
    drv(1'b1, 64'h20, 8'h77);
    #1;
    step();
    drv(1'b0, 64'h20, 8'h00);
    #1;
    chk("t3_rd_ready", ready2, 1'b1);
    step();
    drv(1'b1, 64'h20, 8'h5A);
    #1;
    chk("t3_stall_a", ready2, 1'b0);
    chk("t3_no_beat_yet", rdv2, 1'b0);
    step();
    chk("t3_stall_b", ready2, 1'b0);
    chk("t3_old_rdv", rdv2, 1'b1);
    chk("t3_old_rdata", rdat2, 8'h77);
    step();
    chk("t3_wr_ready", ready2, 1'b1);
    step();
    drv(1'b0, 64'h20, 8'h00);
    #1;
    chk("t3_reread_ready", ready2, 1'b1);
    step();
    idle();
    step();
    chk("t3_new_rdv", rdv2, 1'b1);
    chk("t3_new_rdata", rdat2, 8'h5A);

    // Address aliasing above ADDR_W
    idle_n(6);
    drv(1'b1, 64'h1003, 8'h3C);
    #1;
    step();
    drv(1'b0, 64'h0003, 8'h00);
    #1;
    step();
    idle();
    step();
    chk("t4_alias_rdv", rdv2, 1'b1);
    chk("t4_alias_rdata", rdat2, 8'h3C);
    drv(1'b0, 64'hFFFF_0000_0000_0003, 8'h00);
    #1;
    step();
    idle();
    step();
    chk("t4_alias_hi_rdata", rdat2, 8'h3C);

    // Reset with reads in flight (latency-4 instance)
    idle_n(8);
    drv(1'b0, 64'h10, 8'h00);
    #1;
    chk("t5_rd_ready", ready4, 1'b1);
    step();
    step();
    idle();
    #1;
    chk("t5_outst_2", u_dut4.outstanding_q, 3'd2);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", ready4, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("t5_outst_cleared", u_dut4.outstanding_q, 3'd0);
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_beat_after_rst", rdv4, 1'b0);
      chk("t5_no_beat_after_rst_lat2", rdv2, 1'b0);
      step();
    end
    chk("t5_outst_still_0", u_dut4.outstanding_q, 3'd0);
    drv(1'b0, 64'h10, 8'h00);
    #1;
    chk("t5_ready_post", ready4, 1'b1);
    step();
    idle();
    step();
    step();
    chk("t5_lat4_not_yet", rdv4, 1'b0);
    step();
    chk("t5_rdv", rdv4, 1'b1);
    chk("t5_rdata_kept", rdat4, 8'hA5);

    // Latency 1, alternating reads every cycle
    idle_n(6);
    drv(1'b1, 64'h0, 8'hC3);
    #1;
    step();
    drv(1'b1, 64'h1, 8'h3C);
    #1;
    step();
    idle();
    step();
    chk("t6_idle_rdv", rdv1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      drv(1'b0, 64'(j % 2), 8'h00);
      #1;
      chk("t6_ready", ready1, 1'b1);
      step();
      chk("t6_rdv", rdv1, 1'b1);
      chk("t6_rdata", rdat1, (j % 2 == 1) ? 8'h3C : 8'hC3);
    end
    idle();
    step();
    chk("t6_end_rdv", rdv1, 1'b0);
    chk("t6_end_rdata", rdat1, 8'h00);
    chk("t6_outst_0", u_dut1.outstanding_q, 3'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_serial_mem.md
BYTE_SERIAL_MEM -- requirements
Module: byte_serial_mem

Interface
REQ-001 Parameter ADDR_W, default 12: number of low address bits used; storage is 2^ADDR_W bytes.
REQ-002 Parameter READ_LAT, default 2, legal 1..7: cycles from read acceptance to the r_data_valid beat.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 mode  input  1  request type: 0 = read, 1 = write.
REQ-006 valid  input  1  requester has a one-byte request on mode/addr/w_data.
REQ-007 ready  output  1  block accepts the request this cycle.
REQ-008 addr  input  64  byte address; only addr[ADDR_W-1:0] is used.
REQ-009 w_data  input  8  write byte.
REQ-010 r_data_valid  output  1  one-cycle strobe: r_data holds a returned read byte.
REQ-011 r_data  output  8  returned read byte.

Function
REQ-012 A request is accepted in a cycle with valid=1 and ready=1; no other cycle changes storage or starts a read.
REQ-013 ready is combinational: 0 while rst=1; 0 when valid=1, mode=1 and outstanding!=0 (write-after-read stall); 1 otherwise.
REQ-014 Accepted write: mem[addr[ADDR_W-1:0]] <= w_data at that edge; it produces no response beat.
REQ-015 Accepted read: mem[addr[ADDR_W-1:0]] is sampled at the acceptance edge and enters a READ_LAT-deep delay line of {valid, data} stages.
REQ-016 The byte is presented with r_data_valid=1 exactly READ_LAT cycles after the acceptance edge, for exactly one cycle. There is no backpressure on the return path.
REQ-017 Back-to-back reads, one per cycle, are accepted without stall. They return in acceptance order, one byte per cycle, with no gaps.
REQ-018 r_data = 8'h00 in every cycle where r_data_valid=0.
REQ-019 outstanding is a 3-bit count of reads accepted but not yet returned. It maximum is READ_LAT and it never wraps.
REQ-020 outstanding update per edge: +1 on read accept, -1 on a return beat, unchanged when both occur in the same cycle.
REQ-021 A write waiting on outstanding!=0 keeps ready=0. It is accepted in the first cycle in which outstanding==0 and valid=1.
REQ-022 Ordering: a read accepted in any cycle after a write accept sees the written byte. A read accepted in the same cycle as that write cannot occur (REQ-013 rules it out).
REQ-023 Address wrap: addresses differing only above bit ADDR_W-1 alias to the same byte.
REQ-024 mode, addr and w_data are ignored when valid=0. ready may be 1 with valid=0.

Reset
REQ-025 While rst=1 at an edge, the following are cleared: all delay-line stages, outstanding=0, r_data_valid=0, r_data=8'h00, and ready=0 combinationally.
REQ-026 Reset asserted mid-operation discards all in-flight reads; no return beat appears after the reset edge.
REQ-027 Storage contents are not affected by reset.
REQ-028 The first request can be accepted in the first cycle with rst=0.

Verification
REQ-029 Write addr 0x10 = 8'hA5, then read 0x10 (READ_LAT=2) -> r_data_valid=1, r_data=8'hA5 exactly 2 cycles after the read accept, and a single beat.
REQ-030 Write 8 bytes 0x11..0x88 at 0x100..0x107, then 8 back-to-back reads -> ready=1 throughout, 8 consecutive beats 0x11..0x88 in order, outstanding peaks at 2.
REQ-031 Read 0x20 followed immediately by a write 0x20 = 8'h5A -> ready=0 for the write until the read beat returns the old value; the write is then accepted; a re-read returns 8'h5A.
REQ-032 Write 0x1003 = 8'h3C with ADDR_W=12, then read 0x0003 -> returns 8'h3C (alias).
REQ-033 Accept two reads, then assert rst for one cycle before either returns -> no r_data_valid after reset, outstanding=0. A stored byte written before reset still reads back correctly.
REQ-034 READ_LAT=1, alternating reads of 0x0 and 0x1 every cycle for 16 cycles -> each beat one cycle after its accept, r_data=8'h00 in every non-valid cycle.
